core: RTL and testbench

CORE -- requirements
Module: core

---
 rtl/core.sv | 110 +++++++++++
 tb/tb_core.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/core.sv
// Two-cycle FETCH/EXEC accumulator-free 16-register core with combinational memory port.
// Each instruction takes one fetch edge plus one execute edge; en=0 freezes all state.
module core (
   input  logic        clk,
   input  logic        en,
   input  logic        master,
   input  logic        rst,
   input  logic [15:0] start_pc,
   output logic        halted,
   output logic [15:0] mem_addr,
   input  logic [15:0] mem_data
);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;

   localparam logic [3:0] OP_MOV  = 4'd0;
   localparam logic [3:0] OP_ADD  = 4'd1;
   localparam logic [3:0] OP_JMP  = 4'd2;
   localparam logic [3:0] OP_HALT = 4'd3;
   localparam logic [3:0] OP_LD   = 4'd4;
   localparam logic [3:0] OP_LDR  = 4'd5;
   localparam logic [3:0] OP_JEQ  = 4'd6;
   localparam logic [3:0] OP_JLT  = 4'd7;
   localparam logic [3:0] OP_JGT  = 4'd8;

   state_t      state_q;
   logic [15:0] pc_q;
   logic [15:0] ir_q;
   logic [15:0] rf_q [16];
   logic        halted_q;

   logic [3:0]  op;
   logic [3:0]  ra;
   logic [3:0]  rb;
   logic [3:0]  rc;
   logic [7:0]  imm8;
   logic [11:0] imm12;
   logic [15:0] ra_val;
   logic [15:0] rb_val;
   logic [15:0] rc_val;

   assign op     = ir_q[15:12];
   assign ra     = ir_q[11:8];
   assign rb     = ir_q[7:4];
   assign rc     = ir_q[3:0];
   assign imm8   = ir_q[7:0];
   assign imm12  = ir_q[11:0];
   assign ra_val = rf_q[ra];
   assign rb_val = rf_q[rb];
   assign rc_val = rf_q[rc];
   assign halted = halted_q;

   // Loads redirect the read port only during their execute cycle.
   always_comb begin
      mem_addr = pc_q;
      if (state_q == S_EXEC) begin
         if (op == OP_LD) begin
            mem_addr = {8'h00, imm8};
         end else if (op == OP_LDR) begin
            mem_addr = rb_val;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q     <= start_pc;
         ir_q     <= 16'h0000;
         halted_q <= 1'b0;
         state_q  <= master ? S_FETCH : S_IDLE;
         for (int i = 0; i < 16; i++) begin
            rf_q[i] <= 16'h0000;
         end
      end else if (en) begin
         case (state_q)
            S_IDLE: begin
               if (master) begin
                  state_q <= S_FETCH;
               end
            end
            S_FETCH: begin
               ir_q    <= mem_data;
               pc_q    <= pc_q + 16'd1;
               state_q <= S_EXEC;
            end
            S_EXEC: begin
               state_q <= S_FETCH;
               case (op)
                  OP_MOV:  rf_q[ra] <= {8'h00, imm8};
                  OP_ADD:  rf_q[ra] <= rb_val + rc_val;
                  OP_JMP:  pc_q     <= {4'h0, imm12};
                  OP_HALT: begin
                     halted_q <= 1'b1;
                     state_q  <= S_HALT;
                  end
                  OP_LD:   rf_q[ra] <= mem_data;
                  OP_LDR:  rf_q[ra] <= mem_data;
                  OP_JEQ:  if (ra_val == rb_val) pc_q <= rc_val;
                  OP_JLT:  if (ra_val <  rb_val) pc_q <= rc_val;
                  OP_JGT:  if (ra_val >  rb_val) pc_q <= rc_val;
                  default: ;
               endcase
            end
            S_HALT: state_q <= S_HALT;
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_core.sv
// Directed-vector bench for core: small program images with hand-computed results.
module tb_core;

   logic        clk;
   logic        en;
   logic        master;
   logic        rst;
   logic [15:0] start_pc;
   logic        halted;
   logic [15:0] mem_addr;
   logic [15:0] mem_data;

   logic [15:0] mem [256];
   int          total;
   int          bad;

   core dut (
      .clk      (clk),
      .en       (en),
      .master   (master),
      .rst      (rst),
      .start_pc (start_pc),
      .halted   (halted),
      .mem_addr (mem_addr),
      .mem_data (mem_data)
   );

   assign mem_data = mem[mem_addr[7:0]];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic clr_mem();
      for (int i = 0; i < 256; i++) mem[i] = 16'h3000;
   endtask

   // Pulse reset inside the low phase so the next rising edge is the first fetch.
   task automatic do_rst(input logic [15:0] spc, input logic m);
      start_pc = spc;
      master   = m;
      rst      = 1'b1;
      #2;
      rst      = 1'b0;
   endtask

   logic [15:0] jop   [6] = '{16'h6123, 16'h6123, 16'h7123, 16'h7123, 16'h8123, 16'h8123};
   logic [15:0] jr2   [6] = '{16'h0207, 16'h0208, 16'h0208, 16'h0207, 16'h0206, 16'h0207};
   logic [15:0] jdest [6] = '{16'h0010, 16'h0004, 16'h0010, 16'h0004, 16'h0010, 16'h0004};

   initial begin
      total    = 0;
      bad      = 0;
      en       = 1'b1;
      master   = 1'b1;
      rst      = 1'b0;
      start_pc = 16'h0000;
      clr_mem();
      @(negedge clk);

      // Basic program; reset state observed while rst is held.
      mem[0] = 16'h0105; mem[1] = 16'h1211; mem[2] = 16'h3000;
      start_pc = 16'h0000;
      rst = 1'b1;
      #1;
      chk("rst_pc", 32'(dut.pc_q), 32'h0);
      chk("rst_halted", 32'(halted), 32'h0);
      chk("rst_addr", 32'(mem_addr), 32'h0);
      chk("rst_ir", 32'(dut.ir_q), 32'h0);
      for (int i = 0; i < 16; i++) chk($sformatf("rst_r%0d", i), 32'(dut.rf_q[i]), 32'h0);
      rst = 1'b0;
      tick(1);
      chk("exec_mov_addr", 32'(mem_addr), 32'h1);
      tick(4);
      chk("halt_e5", 32'(halted), 32'h0);
      tick(1);
      chk("halt_e6", 32'(halted), 32'h1);
      chk("prog1_r1", 32'(dut.rf_q[1]), 32'h5);
      chk("prog1_r2", 32'(dut.rf_q[2]), 32'hA);
      tick(4);
      chk("halt_stays", 32'(halted), 32'h1);
      chk("halt_addr", 32'(mem_addr), 32'h3);

      // Reset after HALT takes effect without a clock edge.
      start_pc = 16'h0030;
      rst = 1'b1;
      #1;
      chk("arst_halted", 32'(halted), 32'h0);
      chk("arst_addr", 32'(mem_addr), 32'h30);
      rst = 1'b0;
      @(negedge clk);

      // ADD without overflow, then wrap-around.
      clr_mem();
      mem[0] = 16'h0FFF; mem[1] = 16'h0E01; mem[2] = 16'h1FFE;
      do_rst(16'h0000, 1'b1);
      tick(8);
      chk("add_r15", 32'(dut.rf_q[15]), 32'h0100);
      chk("add_halt", 32'(halted), 32'h1);
      mem[0] = 16'h4F10; mem[16] = 16'hFFFF;
      do_rst(16'h0000, 1'b1);
      tick(2);
      chk("ld_ffff", 32'(dut.rf_q[15]), 32'hFFFF);
      tick(6);
      chk("add_wrap", 32'(dut.rf_q[15]), 32'h0000);

      // LD and LDR address and data.
      clr_mem();
      mem[0] = 16'h4320; mem[1] = 16'h0122; mem[2] = 16'h5510;
      mem[32] = 16'hBEEF; mem[34] = 16'h1234;
      do_rst(16'h0000, 1'b1);
      tick(1);
      chk("ld_addr", 32'(mem_addr), 32'h0020);
      tick(1);
      chk("ld_r3", 32'(dut.rf_q[3]), 32'hBEEF);
      tick(3);
      chk("ldr_addr", 32'(mem_addr), 32'h0022);
      tick(1);
      chk("ldr_r5", 32'(dut.rf_q[5]), 32'h1234);

      // Conditional jumps: r1=7 versus r2 from table, r3=0x10 target.
      for (int k = 0; k < 6; k++) begin
         clr_mem();
         mem[0] = 16'h0107; mem[1] = jr2[k]; mem[2] = 16'h0310; mem[3] = jop[k];
         do_rst(16'h0000, 1'b1);
         tick(8);
         chk($sformatf("jump_%0d", k), 32'(mem_addr), 32'(jdest[k]));
      end

      // en freeze mid-instruction, then JMP.
      clr_mem();
      mem[0] = 16'h0105; mem[1] = 16'h1211; mem[2] = 16'h2005;
      do_rst(16'h0000, 1'b1);
      tick(3);
      en = 1'b0;
      tick(3);
      chk("frz_pc", 32'(dut.pc_q), 32'h2);
      chk("frz_addr", 32'(mem_addr), 32'h2);
      chk("frz_r2", 32'(dut.rf_q[2]), 32'h0);
      chk("frz_state", 32'(dut.state_q), 32'h2);
      en = 1'b1;
      tick(1);
      chk("resume_r2", 32'(dut.rf_q[2]), 32'hA);
      tick(2);
      chk("jmp_addr", 32'(mem_addr), 32'h5);
      tick(2);
      chk("jmp_halt", 32'(halted), 32'h1);

      // master=0 idles at start_pc until raised.
      clr_mem();
      mem[8] = 16'h0105;
      do_rst(16'h0008, 1'b0);
      tick(3);
      chk("idle_addr", 32'(mem_addr), 32'h8);
      chk("idle_r1", 32'(dut.rf_q[1]), 32'h0);
      chk("idle_state", 32'(dut.state_q), 32'h0);
      master = 1'b1;
      tick(3);
      chk("master_r1", 32'(dut.rf_q[1]), 32'h5);
      tick(2);
      chk("master_halt", 32'(halted), 32'h1);

      // Reset during EXEC aborts the write.
      clr_mem();
      mem[0] = 16'h0105;
      do_rst(16'h0000, 1'b1);
      tick(1);
      rst = 1'b1;
      tick(1);
      chk("abort_r1", 32'(dut.rf_q[1]), 32'h0);
      chk("abort_pc", 32'(dut.pc_q), 32'h0);
      rst = 1'b0;
      tick(2);
      chk("after_abort_r1", 32'(dut.rf_q[1]), 32'h5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
